// File: rtl/wb_sdram_arbiter.sv
`default_nettype none
// ============================================================================
// Module : wb_sdram_arbiter
// Round-robin Wishbone arbiter sharing the sdrc_top slave port among NM
// masters, with init gating and a stall watchdog.
// Rev    : 1.0
// ============================================================================
module wb_sdram_arbiter #(
  parameter int NM      = 4,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic                 sdr_init_done,
  input  logic [NM-1:0]        m_cyc_i,
  input  logic [NM-1:0]        m_stb_i,
  input  logic [NM-1:0]        m_we_i,
  input  logic [NM*AW-1:0]     m_adr_i,
  input  logic [NM*DW-1:0]     m_dat_i,
  input  logic [NM*(DW/8)-1:0] m_sel_i,
  output logic [DW-1:0]        m_dat_o,
  output logic [NM-1:0]        m_ack_o,
  output logic [NM-1:0]        m_err_o,
  output logic                 s_cyc_o,
  output logic                 s_stb_o,
  output logic                 s_we_o,
  output logic [AW-1:0]        s_adr_o,
  output logic [DW-1:0]        s_dat_o,
  output logic [DW/8-1:0]      s_sel_o,
  input  logic [DW-1:0]        s_dat_i,
  input  logic                 s_ack_i,
  output logic [NM-1:0]        grant_o,
  output logic                 timeout_o
);

  localparam int c_SW = DW / 8;
  localparam int c_IW = (NM > 1) ? $clog2(NM) : 1;
  localparam int c_CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_OWN   = 2'd1,
    S_ERR   = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t            r_state;
  logic [NM-1:0]     r_grant;
  logic [c_IW-1:0]   r_owner;
  logic [c_IW-1:0]   r_last;
  logic [c_CW-1:0]   r_cnt;
  logic [NM-1:0]     r_err;
  logic              r_timeout;

  logic              w_own;
  logic              w_own_cyc;
  logic              w_own_stb;
  logic              w_stall;
  logic [c_IW-1:0]   w_win;
  logic [c_IW-1:0]   w_idx;
  logic              w_found;

  // Rotating priority: first requester above the previous owner, wrapping.
  always_comb begin
    w_win   = r_last;
    w_idx   = r_last;
    w_found = 1'b0;
    for (int k = 1; k <= NM; k++) begin
      w_idx = c_IW'((int'(r_last) + k) % NM);
      if (!w_found && m_cyc_i[w_idx]) begin
        w_win   = w_idx;
        w_found = 1'b1;
      end
    end
  end

  assign w_own     = (r_state == S_OWN);
  assign w_own_cyc = m_cyc_i[r_owner];
  assign w_own_stb = m_stb_i[r_owner];

  assign s_cyc_o = w_own & w_own_cyc;
  assign s_stb_o = w_own & w_own_cyc & w_own_stb;
  assign s_we_o  = w_own & m_we_i[r_owner];
  assign s_adr_o = w_own ? m_adr_i[r_owner*AW +: AW] : '0;
  assign s_dat_o = w_own ? m_dat_i[r_owner*DW +: DW] : '0;
  assign s_sel_o = w_own ? m_sel_i[r_owner*c_SW +: c_SW] : '0;

  assign m_dat_o   = s_dat_i;
  assign m_ack_o   = (w_own && s_ack_i && w_own_cyc && w_own_stb) ? r_grant : '0;
  assign m_err_o   = r_err;
  assign timeout_o = r_timeout;
  assign grant_o   = r_grant;

  assign w_stall = s_stb_o & ~s_ack_i;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state   <= S_IDLE;
      r_grant   <= '0;
      r_owner   <= '0;
      r_last    <= c_IW'(NM - 1);
      r_cnt     <= '0;
      r_err     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_err     <= '0;
      r_timeout <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (sdr_init_done && (|m_cyc_i)) begin
            r_owner <= w_win;
            r_grant <= NM'(1) << w_win;
            r_state <= S_OWN;
          end
        end
        S_OWN: begin
          if (!w_own_cyc) begin
            r_grant <= '0;
            r_last  <= r_owner;
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end else if (w_stall) begin
            // Abort on the TIMEOUT-th consecutive stalled cycle.
            if (r_cnt == c_CW'(TIMEOUT - 1)) begin
              r_cnt     <= '0;
              r_err     <= r_grant;
              r_timeout <= 1'b1;
              r_state   <= S_ERR;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end else begin
            r_cnt <= '0;
          end
        end
        S_ERR: begin
          r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (!w_own_cyc) begin
            r_grant <= '0;
            r_last  <= r_owner;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_sdram_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_wb_sdram_arbiter
// Self-checking bench for wb_sdram_arbiter against a round-robin owner model.
// Rev    : 1.0
// ============================================================================
module tb_wb_sdram_arbiter;

  localparam int NM      = 4;
  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int SW      = DW / 8;
  localparam int TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              init;
  logic [NM-1:0]     m_cyc_i, m_stb_i, m_we_i;
  logic [NM*AW-1:0]  m_adr_i;
  logic [NM*DW-1:0]  m_dat_i;
  logic [NM*SW-1:0]  m_sel_i;
  logic [DW-1:0]     m_dat_o;
  logic [NM-1:0]     m_ack_o, m_err_o;
  logic              s_cyc_o, s_stb_o, s_we_o;
  logic [AW-1:0]     s_adr_o;
  logic [DW-1:0]     s_dat_o;
  logic [SW-1:0]     s_sel_o;
  logic [DW-1:0]     s_dat_i;
  logic              s_ack_i;
  logic [NM-1:0]     grant_o;
  logic              timeout_o;

  int n_pass  = 0;
  int n_total = 0;

  // Master-side stimulus state and the owner model (previous owner).
  int            req_mask, stb_mask, we_mask;
  logic [AW-1:0] adr_a [NM];
  logic [DW-1:0] dat_a [NM];
  logic [SW-1:0] sel_a [NM];
  int            last;

  wb_sdram_arbiter #(.NM(NM), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .wb_clk_i     (clk),
    .wb_rst_i     (rst),
    .sdr_init_done(init),
    .m_cyc_i      (m_cyc_i),
    .m_stb_i      (m_stb_i),
    .m_we_i       (m_we_i),
    .m_adr_i      (m_adr_i),
    .m_dat_i      (m_dat_i),
    .m_sel_i      (m_sel_i),
    .m_dat_o      (m_dat_o),
    .m_ack_o      (m_ack_o),
    .m_err_o      (m_err_o),
    .s_cyc_o      (s_cyc_o),
    .s_stb_o      (s_stb_o),
    .s_we_o       (s_we_o),
    .s_adr_o      (s_adr_o),
    .s_dat_o      (s_dat_o),
    .s_sel_o      (s_sel_o),
    .s_dat_i      (s_dat_i),
    .s_ack_i      (s_ack_i),
    .grant_o      (grant_o),
    .timeout_o    (timeout_o)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL global_timeout: observed no finish, expected finish");
    $fatal(1, "bench time limit");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic drive();
    m_cyc_i = NM'(req_mask);
    m_stb_i = NM'(stb_mask);
    m_we_i  = NM'(we_mask);
    for (int i = 0; i < NM; i++) begin
      m_adr_i[i*AW +: AW] = adr_a[i];
      m_dat_i[i*DW +: DW] = dat_a[i];
      m_sel_i[i*SW +: SW] = sel_a[i];
    end
  endtask

  function automatic int next_owner(input int req, input int lst);
    for (int k = 1; k <= NM; k++)
      if (((req >> ((lst + k) % NM)) & 1) != 0) return (lst + k) % NM;
    return -1;
  endfunction

  // Fresh random bus contents on every master; owner strobes with given direction.
  task automatic set_beat(input int w, input bit wr);
    for (int i = 0; i < NM; i++) begin
      adr_a[i] = $urandom;
      dat_a[i] = $urandom;
      sel_a[i] = SW'($urandom);
    end
    stb_mask = ($urandom & req_mask & ((1 << NM) - 1)) | (1 << w);
    we_mask  = $urandom & ((1 << NM) - 1);
    if (wr) we_mask = we_mask | (1 << w);
    else    we_mask = we_mask & ~(1 << w);
    drive();
  endtask

  // One full tenure starting from IDLE with req_mask already pending.
  task automatic tenure(input int nbeats, input bit rereq, input bit wr, input bit drop_init);
    int w;
    int acks;
    w = next_owner(req_mask, last);
    stb_mask = 0;
    s_ack_i  = 1'b0;
    drive();
    cyc();
    #1;
    chk("grant", grant_o, 64'(1) << w);
    chk("s_cyc_on", s_cyc_o, 1);
    if (drop_init) init = 1'b0;
    acks = 0;
    for (int b = 0; b < nbeats; b++) begin
      set_beat(w, wr);
      s_ack_i = 1'b0;
      repeat ($urandom_range(0, 2)) begin
        #1;
        chk("stall_stb", s_stb_o, 1);
        chk("stall_noack", m_ack_o, 0);
        cyc();
      end
      s_ack_i = 1'b1;
      s_dat_i = $urandom;
      #1;
      chk("adr_mux", s_adr_o, adr_a[w]);
      chk("dat_mux", s_dat_o, dat_a[w]);
      chk("sel_mux", s_sel_o, sel_a[w]);
      chk("we_mux", s_we_o, wr);
      chk("rdata", m_dat_o, s_dat_i);
      chk("ack_route", m_ack_o, 64'(1) << w);
      chk("no_err", {m_err_o, timeout_o}, 0);
      if (((m_ack_o >> w) & 1) != 0) acks++;
      cyc();
      s_ack_i  = 1'b0;
      stb_mask = stb_mask & ~(1 << w);
      drive();
      if ($urandom_range(0, 3) == 0) begin
        s_ack_i = 1'b1;
        #1;
        chk("ack_without_stb", m_ack_o, 0);
        chk("stb_low", s_stb_o, 0);
        cyc();
        s_ack_i = 1'b0;
      end
    end
    chk("ack_count", acks, nbeats);
    req_mask = req_mask & ~(1 << w);
    drive();
    #1;
    chk("s_cyc_release", s_cyc_o, 0);
    last = w;
    cyc();
    #1;
    chk("grant_clear", grant_o, 0);
    chk("gap_cyc", s_cyc_o, 0);
    chk("gap_adr", s_adr_o, 0);
    if (rereq) req_mask = req_mask | (1 << w);
    drive();
  endtask

  initial begin
    int w;
    rst = 1'b1; init = 1'b0; s_ack_i = 1'b0; s_dat_i = '0;
    req_mask = 0; stb_mask = 0; we_mask = 0;
    for (int i = 0; i < NM; i++) begin
      adr_a[i] = '0; dat_a[i] = '0; sel_a[i] = '0;
    end
    drive();
    last = NM - 1;

    // Reset state
    repeat (3) cyc();
    #1;
    chk("rst_grant", grant_o, 0);
    chk("rst_scyc", {s_cyc_o, s_stb_o, s_we_o}, 0);
    chk("rst_sadr", s_adr_o, 0);
    chk("rst_sdat", s_dat_o, 0);
    chk("rst_ssel", s_sel_o, 0);
    chk("rst_ack", m_ack_o, 0);
    chk("rst_err", m_err_o, 0);
    chk("rst_timeout", timeout_o, 0);
    rst = 1'b0;

    // First grant after reset goes to master 0
    init = 1'b1; req_mask = 1;
    tenure(1, 0, 0, 0);

    // Init gating, starting from a fresh reset
    rst = 1'b1;
    cyc();
    rst = 1'b0; last = NM - 1;
    init = 1'b0; req_mask = (1 << NM) - 1; drive();
    for (int i = 0; i < 50; i++) begin
      cyc();
      #1;
      chk("gate_grant", grant_o, 0);
      chk("gate_scyc", s_cyc_o, 0);
    end
    init = 1'b1;

    // Round robin with all masters re-requesting: 0,1,2,3,0
    for (int r = 0; r < 5; r++) tenure(1, 1, r[0], 0);

    // Burst hold: master 2 bursts 8 writes while master 1 waits
    req_mask = 2; tenure(1, 0, 0, 0);
    req_mask = 6; tenure(8, 0, 1, 0);
    tenure(1, 0, 0, 0);

    // Init falling mid-tenure: tenure finishes, then no new grants
    req_mask = 8; tenure(2, 1, 0, 1);
    for (int i = 0; i < 5; i++) begin
      cyc();
      #1;
      chk("init_low_grant", grant_o, 0);
    end
    init = 1'b1;

    // Randomized tenures
    for (int t = 0; t < 30; t++) begin
      req_mask = $urandom_range(1, (1 << NM) - 1);
      tenure($urandom_range(1, 4), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
    end

    // Watchdog: slave never acknowledges
    req_mask = 5; stb_mask = 0; drive();
    w = next_owner(req_mask, last);
    cyc();
    #1;
    chk("wd_grant", grant_o, 64'(1) << w);
    set_beat(w, 0);
    s_ack_i = 1'b0;
    for (int i = 1; i < TIMEOUT; i++) cyc();
    #1;
    chk("wd_pre_err", {m_err_o, timeout_o}, 0);
    chk("wd_pre_cyc", s_cyc_o, 1);
    cyc();
    #1;
    chk("wd_err", m_err_o, 64'(1) << w);
    chk("wd_timeout", timeout_o, 1);
    chk("wd_err_cyc", {s_cyc_o, s_stb_o}, 0);
    chk("wd_err_ack", m_ack_o, 0);
    cyc();
    #1;
    chk("wd_drain_err", {m_err_o, timeout_o}, 0);
    chk("wd_drain_grant", grant_o, 64'(1) << w);
    chk("wd_drain_cyc", s_cyc_o, 0);
    s_ack_i = 1'b1;
    #1;
    chk("wd_drain_ack", m_ack_o, 0);
    s_ack_i = 1'b0;
    repeat (3) cyc();
    #1;
    chk("wd_hold", grant_o, 64'(1) << w);
    req_mask = req_mask & ~(1 << w); stb_mask = 0; drive();
    last = w;
    cyc();
    #1;
    chk("wd_release", grant_o, 0);
    tenure(1, 0, 0, 0);

    // Reset mid-tenure during a stall
    req_mask = 8; stb_mask = 0; drive();
    w = next_owner(req_mask, last);
    cyc();
    #1;
    chk("rm_grant", grant_o, 64'(1) << w);
    set_beat(w, 0);
    s_ack_i = 1'b0;
    repeat (5) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    req_mask = (1 << NM) - 1; stb_mask = 0; drive();
    #1;
    chk("rm_grant_clr", grant_o, 0);
    chk("rm_scyc", s_cyc_o, 0);
    chk("rm_err", {m_err_o, timeout_o}, 0);
    last = NM - 1;
    tenure(1, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wb_sdram_arbiter.md
# wb_sdram_arbiter

Round-robin Wishbone arbiter that shares the single Wishbone slave port of the SDRAM controller (`sdrc_top`) between up to `NM` bus masters. It sits directly in front of `sdrc_top` at the `wb_*` boundary and holds off all grants until SDRAM initialization completes. Each grant lasts one full Wishbone cycle (CYC high to CYC low). A stall watchdog terminates a tenure with ERR if the controller never acknowledges.

## Interface
- `NM`, 4, number of masters (2..8)
- `AW`, 32, address width
- `DW`, 32, data width; `SW = DW/8`
- `TIMEOUT`, 1024, max consecutive stalled cycles (STB high, no ACK) before abort; ≥2
- `wb_clk_i`  in  1  single clock
- `wb_rst_i`  in  1  synchronous, active-high reset
- `sdr_init_done`  in  1  SDRAM init complete; gates new grants
- `m_cyc_i`, `m_stb_i`, `m_we_i`  in  NM each  per-master Wishbone controls; bit i = master i
- `m_adr_i`  in  NM*AW  master i at `[i*AW +: AW]`
- `m_dat_i`  in  NM*DW  master i write data at `[i*DW +: DW]`
- `m_sel_i`  in  NM*SW  master i byte selects at `[i*SW +: SW]`
- `m_dat_o`  out  DW  read data, broadcast to all masters (= `s_dat_i`)
- `m_ack_o`, `m_err_o`  out  NM each  per-master ACK / ERR
- `s_cyc_o`, `s_stb_o`, `s_we_o`  out  1 each  to `sdrc_top`
- `s_adr_o`  out  AW; `s_dat_o`  out  DW; `s_sel_o`  out  SW
- `s_dat_i`  in  DW; `s_ack_i`  in  1  from `sdrc_top`
- `grant_o`  out  NM  one-hot current owner; 0 when idle
- `timeout_o`  out  1  one-cycle pulse on watchdog abort

## Operation
- FSM states: IDLE, OWN, ERR, DRAIN.
- **IDLE**
  - If `sdr_init_done` is high and any `m_cyc_i` bit is high, register a grant.
  - Winner is the first requester searching upward (wrapping) from `last+1`, where `last` is the previous owner.
  - Go to OWN.
- **OWN (owner g)**
  - `s_cyc_o = m_cyc_i[g]`.
  - `s_stb_o = m_cyc_i[g] & m_stb_i[g]`.
  - `s_we_o`, `s_adr_o`, `s_dat_o`, `s_sel_o` are muxed from master g.
  - All slave-side muxing is combinational from the registered grant.
  - `m_ack_o[g] = s_ack_i & m_cyc_i[g] & m_stb_i[g]`. All other masters' ACK bits are 0.
  - When `m_cyc_i[g]` is low at a clock edge: clear the grant, set `last=g`, go to IDLE.
- **Watchdog**
  - Counter of width `$clog2(TIMEOUT+1)` increments each cycle `s_stb_o & !s_ack_i` in OWN.
  - It clears on ACK, on `s_stb_o` low, and on leaving OWN.
  - When the counter would reach `TIMEOUT`, go to ERR.
- **ERR**: lasts exactly one cycle.
  - `s_cyc_o = s_stb_o = 0`.
  - `m_err_o[g] = 1`, `timeout_o = 1`.
  - Go to DRAIN.
- **DRAIN**
  - `s_cyc_o = 0`; ACK/ERR outputs are 0; `s_ack_i` is ignored.
  - Grant stays held.
  - When `m_cyc_i[g]` is low: set `last=g`, go to IDLE.
- **Outside OWN**: `s_cyc_o`, `s_stb_o`, `s_we_o` are 0; address, data and select outputs are 0.
- **`sdr_init_done` falling mid-tenure**: the current tenure runs to completion; no further grants are issued.
- **Guarantees**
  - ACK and ERR to a master are never both high.
  - ACK is only ever asserted while that master's CYC and STB are high (Rule 3.35).

## Timing
- **Reset**
  - All outputs are 0 and the state is IDLE.
  - `last = NM-1`, so master 0 wins first.
  - Watchdog counter is 0.
- **Reset mid-tenure**: on the next edge, `s_cyc_o` drops and the transfer is abandoned. No ERR is issued.
- **Grant latency**: `m_cyc_i[i]` is sampled high at edge N; `grant_o` and `s_cyc_o` are high after edge N. The slave first samples them at edge N+1.
- **Release**
  - `s_cyc_o` falls in the same cycle as `m_cyc_i[g]` (combinational).
  - The grant clears at the next edge.
  - The earliest next grant is one edge later, so `s_cyc_o` is low for at least one full cycle between tenures.
- **ACK path**: `s_ack_i` to `m_ack_o` is zero latency (combinational). Data passes straight through in both directions.
- **Simultaneous requests**: exactly one grant per arbitration. Rotation is fair: with all NM requesting continuously, each master is granted once every NM tenures.
- **Timeout**: with ACK never arriving, `m_err_o` is high exactly `TIMEOUT` cycles after the first stalled STB cycle.

## Test plan
- **Reset defaults**: reset, then `sdr_init_done=1`, `m_cyc_i=4'b0001` → master 0 is granted one edge later; `s_cyc_o=1`; a single read returns `m_dat_o=s_dat_i` with `m_ack_o=4'b0001`.
- **Init gating**: `sdr_init_done=0`, `m_cyc_i=4'b1111` for 50 cycles → `grant_o=0`, `s_cyc_o=0`. Raise init → master 0 is granted first.
- **Round-robin fairness**: all 4 masters each issue 1-beat cycles back-to-back → grant order 0,1,2,3,0; `s_cyc_o` low for ≥1 cycle between each tenure.
- **Burst hold**: master 2 holds CYC for an 8-beat write burst while master 1 requests → no switch until master 2 drops CYC; master 1 is granted next, and only 8 ACKs are routed to master 2.
- **Watchdog**: `TIMEOUT=16`, slave never ACKs → `m_err_o[g]` and `timeout_o` pulse 16 cycles after STB; `s_cyc_o` drops; the grant is held until the master drops CYC, then arbitration resumes.
- **Reset mid-tenure**: assert `wb_rst_i` during an OWN stall → all outputs 0 after the edge, no ERR; master 0 has priority again.
